// File: rtl/vc_fifo_pkg.sv
// Shared defaults for the virtual-channel FIFO bank and the width helper for
// per-VC occupancy counters.
package vc_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_VC     = 2;
  localparam int DEF_CNT_WIDTH  = DEF_ADDR_WIDTH + 1;

  // The counter needs one extra bit so it can hold DEPTH itself.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Bus bundle between a traffic source/sink and the VC FIFO bank.
// The master drives requests and thresholds. The slave (the bank) drives data and status.
interface vc_fifo_bank_if
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_VC     = DEF_NUM_VC
) ();

  // Handshake: wr_enable[k] is a write request and ~full[k] is its ready.
  // rd_enable[k] is a read request and ~empty[k] is its ready. A request is
  // accepted on a rising edge only when both are high. An accepted read
  // returns its word on data_out one cycle later, marked by data_out_valid[k].
  logic [NUM_VC-1:0]                   wr_enable;
  logic [NUM_VC-1:0]                   rd_enable;
  logic [NUM_VC*DATA_WIDTH-1:0]        data_in;
  logic [NUM_VC*ADDR_WIDTH-1:0]        umbral_empty;
  logic [NUM_VC*ADDR_WIDTH-1:0]        umbral_full;
  logic [NUM_VC*DATA_WIDTH-1:0]        data_out;
  logic [NUM_VC-1:0]                   data_out_valid;
  logic [NUM_VC*DATA_WIDTH-1:0]        data_peek;
  logic [NUM_VC-1:0]                   full;
  logic [NUM_VC-1:0]                   empty;
  logic [NUM_VC-1:0]                   almost_full;
  logic [NUM_VC-1:0]                   almost_empty;
  logic [NUM_VC-1:0]                   error;
  logic [NUM_VC*(ADDR_WIDTH+1)-1:0]    count;

  modport master (
    output wr_enable, rd_enable, data_in, umbral_empty, umbral_full,
    input  data_out, data_out_valid, data_peek, full, empty,
           almost_full, almost_empty, error, count
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, umbral_empty, umbral_full,
    output data_out, data_out_valid, data_peek, full, empty,
           almost_full, almost_empty, error, count
  );

endinterface

// File: rtl/vc_fifo_chan.sv
// Single virtual-channel FIFO with registered read data, threshold flags and a sticky error flag.
// The optional head-word look-ahead is enabled with the VC_FIFO_PEEK_EN macro.
module vc_fifo_chan
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] umbral_empty,
  input  logic [ADDR_WIDTH-1:0] umbral_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] data_peek,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   af_thr;

  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign wr_acc = wr_enable & ~full;
  assign rd_acc = rd_enable & ~empty;
  // A request paired with an accepted request on the other side is a normal turn-around, not an error.
  assign overflow  = wr_enable & full  & ~rd_enable;
  assign underflow = rd_enable & empty & ~wr_enable;

  assign af_thr       = DEPTH_CNT - {1'b0, umbral_full};
  assign almost_full  = (count >= af_thr) & ~full;
  assign almost_empty = (count != '0) & (count <= {1'b0, umbral_empty});

`ifdef VC_FIFO_PEEK_EN
  assign data_peek = mem[rd_ptr];
`else
  assign data_peek = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      error          <= 1'b0;
    end else if (!init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      error          <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      data_out_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow | underflow) error <= 1'b1;
    end
  end

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent virtual-channel FIFOs behind one bus interface.
// The optional head-word peek is enabled with the VC_FIFO_PEEK_EN macro.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_VC     = DEF_NUM_VC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  vc_fifo_bank_if.slave  bus
);

  localparam int CW = cnt_width(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] dout_a  [NUM_VC];
  logic [DATA_WIDTH-1:0] peek_a  [NUM_VC];
  logic [CW-1:0]         cnt_a   [NUM_VC];
  logic                  valid_a [NUM_VC];
  logic                  full_a  [NUM_VC];
  logic                  empty_a [NUM_VC];
  logic                  af_a    [NUM_VC];
  logic                  ae_a    [NUM_VC];
  logic                  err_a   [NUM_VC];

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    vc_fifo_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chan (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .wr_enable      (bus.wr_enable[k]),
      .rd_enable      (bus.rd_enable[k]),
      .data_in        (bus.data_in[k*DATA_WIDTH +: DATA_WIDTH]),
      .umbral_empty   (bus.umbral_empty[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .umbral_full    (bus.umbral_full[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .data_out       (dout_a[k]),
      .data_out_valid (valid_a[k]),
      .data_peek      (peek_a[k]),
      .full           (full_a[k]),
      .empty          (empty_a[k]),
      .almost_full    (af_a[k]),
      .almost_empty   (ae_a[k]),
      .error          (err_a[k]),
      .count          (cnt_a[k])
    );
  end

  // Flatten per-channel results into the packed bus layout, VC k at slice k.
  always_comb begin
    bus.data_out       = '0;
    bus.data_peek      = '0;
    bus.count          = '0;
    bus.data_out_valid = '0;
    bus.full           = '0;
    bus.empty          = '0;
    bus.almost_full    = '0;
    bus.almost_empty   = '0;
    bus.error          = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      bus.data_out[k*DATA_WIDTH +: DATA_WIDTH]  = dout_a[k];
      bus.data_peek[k*DATA_WIDTH +: DATA_WIDTH] = peek_a[k];
      bus.count[k*CW +: CW]                     = cnt_a[k];
      bus.data_out_valid[k]                     = valid_a[k];
      bus.full[k]                               = full_a[k];
      bus.empty[k]                              = empty_a[k];
      bus.almost_full[k]                        = af_a[k];
      bus.almost_empty[k]                       = ae_a[k];
      bus.error[k]                              = err_a[k];
    end
  end

endmodule

// File: doc/vc_fifo_bank.md
VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 6, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set per-VC depth DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_VC, default 2, SHALL set the number of independent virtual-channel FIFOs.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 init  in  1  SHALL be a synchronous active-low soft clear.
REQ-007 wr_enable  in  NUM_VC  SHALL carry per-VC write requests.
REQ-008 rd_enable  in  NUM_VC  SHALL carry per-VC read requests.
REQ-009 data_in  in  NUM_VC*DATA_WIDTH  SHALL carry write data; VC k in slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 umbral_empty, umbral_full  in  NUM_VC*ADDR_WIDTH each  SHALL carry per-VC thresholds.
REQ-011 data_out  out  NUM_VC*DATA_WIDTH  SHALL carry registered read data.
REQ-012 data_out_valid  out  NUM_VC  SHALL pulse for one cycle per accepted read.
REQ-013 data_peek  out  NUM_VC*DATA_WIDTH  SHALL carry the head word of each VC.
REQ-014 full, empty, almost_full, almost_empty, error  out  NUM_VC each  SHALL carry per-VC status.
REQ-015 count  out  NUM_VC*(ADDR_WIDTH+1)  SHALL carry per-VC occupancy, range 0..DEPTH.

Function
REQ-016 Each VC SHALL behave independently; no shared storage or arbitration between VCs.
REQ-017 Write SHALL be accepted iff wr_enable[k]=1 and full[k]=0; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 Read SHALL be accepted iff rd_enable[k]=1 and empty[k]=0; mem[rd_ptr] is loaded into data_out next edge, rd_ptr increments modulo DEPTH, data_out_valid[k]=1 that cycle.
REQ-019 Read latency SHALL be exactly one cycle; data_out SHALL hold its last value when no read is accepted.
REQ-020 count SHALL update as count + write_accepted - read_accepted; simultaneous accepted read and write leaves count unchanged.
REQ-021 When full, a simultaneous read and write SHALL accept only the read; when empty, only the write.
REQ-022 full = (count==DEPTH); empty = (count==0), both decoded combinationally from count.
REQ-023 almost_full = (count >= DEPTH-umbral_full) and not full; almost_empty = (count != 0) and (count <= umbral_empty).
REQ-024 Write to full VC (overflow) or read from empty VC (underflow) SHALL be dropped without state change and SHALL set error[k], sticky until reset or init.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no bubble.

Reset
REQ-026 reset=0 SHALL asynchronously clear pointers, count, data_out, data_out_valid, error and memory; empty=1, full=almost_full=almost_empty=0.
REQ-027 init=0 SHALL perform the same clear synchronously at the next edge; requests during init=0 SHALL be ignored and SHALL NOT set error.
REQ-028 Reset or init asserted mid-traffic SHALL discard all stored words; the first post-release write lands at address 0.

Configuration
REQ-029 With VC_FIFO_PEEK_EN defined, data_peek[k] SHALL equal mem[rd_ptr] combinationally (first-word look-ahead for the arbiter); with it undefined, data_peek SHALL be tied to 0 and no peek mux is synthesised.

Structure
REQ-030 Package vc_fifo_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH, NUM_VC constants and the count-width helper constant.
REQ-031 One sub-module vc_fifo_chan SHALL implement a single VC FIFO, instantiated NUM_VC times via generate.

Verification
REQ-032 Reset release, write 0x15 then 0x2A to VC0, read twice -> data_out 0x15 then 0x2A one cycle after each read, valid pulses, count 2->0, VC1 untouched.
REQ-033 Write 16 words to VC1 (umbral_full=3) -> almost_full from count 13 to 15, full at 16; 17th write dropped, error[1]=1, count stays 16.
REQ-034 VC0 full, assert wr_enable and rd_enable together -> read accepted, write dropped, count 15, error[0] stays 0.
REQ-035 VC0 empty, rd_enable alone -> error[0]=1, data_out_valid=0; then simultaneous read+write -> write accepted, count 1.
REQ-036 Write/read 40 words continuously on VC0 -> pointer wrap twice, data order preserved, count never exceeds 1.
REQ-037 Fill VC1 to 9, pulse init low one cycle -> count 0, empty=1, error=0, next write stored at address 0 and read back correctly.
